symbol_window_loader: RTL and testbench
=======================================

// Module: symbol_window_loader
// PURPOSE
//  Upstream feeder for the 50-bit symbol right-shifter.
//  - Accepts a stream of 5-bit symbols and packs them into a 10-lane window (lane k = bits [5k+4:5k]).
//  - Each cycle, downstream removes 0..4 symbols from lane 0.
//  - Drives the shifter's in/shift/fill ports and holds the registered, shifted-and-refilled window.
//  - Empty lanes always hold the pad symbol, so the window is always well formed.
// PARAMETERS
//  PAD_SYM   5'h00   symbol placed in empty lanes; driven on sh_fill
// PORTS
//  clk        in   1    clock, all state updates on rising edge
//  rst        in   1    synchronous reset, active high
//  sym_in     in   5    incoming symbol
//  sym_valid  in   1    sym_in valid
//  sym_ready  out  1    loader can accept sym_in this cycle
//  take       in   3    symbols consumed from lane 0 this cycle (legal 0..4, <= win_count)
//  flush      in   1    discard window contents
//  err_clr    in   1    clear take_err
//  win_data   out  50   registered window, lane 0 = oldest symbol
//  win_count  out  4    valid symbols in window, 0..10
//  take_err   out  1    sticky: an illegal take was seen
//  sh_in      out  50   to shifter in    (= win_data)
//  sh_shift   out  3    to shifter shift (= legal take, else 0)
//  sh_fill    out  5    to shifter fill  (= PAD_SYM)
// BEHAVIOUR
//  Reset:
//  - win_data = {10{PAD_SYM}}, win_count = 0, take_err = 0.
//  - sym_ready = 1 the cycle after reset deasserts.
//  Handshake:
//  - sym_ready = ~flush & (win_count < 10).
//  - Depends only on registered count and flush, never on take.
//  - A transfer happens when sym_valid & sym_ready.
//  Legal take:
//  - take is legal when take <= 4 and take <= win_count; then t = take.
//  - Otherwise t = 0, the window is not shifted, and take_err is set next cycle.
//  - sh_shift = t, so the shifter is never driven to an invalid shift.
//  Per-cycle update (no flush):
//  - c1 = win_count - t.
//  - Window becomes the shifter output (win_data >> 5*t, top t lanes = PAD_SYM).
//  - If a transfer occurs: lane c1 <= sym_in and win_count <= c1 + 1.
//  - Otherwise win_count <= c1.
//  - Simultaneous take and push in the same cycle are both honoured; c1 <= 9 always holds, so no overflow.
//  Flush:
//  - Takes priority over take and push.
//  - win_data <= {10{PAD_SYM}}, win_count <= 0; no symbol is accepted that cycle.
//  - take_err is not changed by flush.
//  take_err:
//  - Set on an illegal take; cleared only by rst or err_clr.
//  - If an illegal take and err_clr arrive in the same cycle, set wins.
//  Invariant: lanes >= win_count always equal PAD_SYM.
//  Latency: one cycle from a push or take to the visible change on win_data / win_count.
//  Reset mid-operation: all state returns to reset values on the next edge and in-flight symbols are lost.
// TESTING
//  1. Reset, push 1..10 with take=0 -> after 10 transfers: win_count=10,
//     win_data={5'd10,5'd9,...,5'd1}, sym_ready=0.
//  2. From test 1, take=3 for one cycle -> win_count=7, lanes0..6=4..10,
//     lanes7..9=PAD_SYM, sym_ready=1, sh_shift was 3.
//  3. win_count=5 (syms 1..5), take=2 plus push 5'h1F -> win_count=4,
//     lanes0..3={3,4,5,5'h1F}, lane4=PAD_SYM.
//  4. win_count=2, take=3; then take=5 -> window unchanged, sh_shift=0,
//     take_err=1 and stays 1 until err_clr pulse -> 0.
//  5. win_count=6, flush with sym_valid=1 and take=1 -> sym_ready=0 that cycle,
//     next cycle win_count=0, win_data all PAD_SYM, take_err unchanged.
//  6. rst asserted while win_count=8 and pushing -> next cycle all outputs at
//     reset values; with PAD_SYM=5'h15, empty lanes read 5'h15.

Source files
------------

// File: rtl/symbol_window_loader.sv
// symbol_window_loader: packs a stream of 5-bit symbols into a 10-lane window.
// Downstream takes 0..4 symbols per cycle from lane 0. The window is
// shifted down by the legal take, refilled with the pad symbol, and then the
// incoming symbol (if any) is dropped into the first free lane.
module symbol_window_loader #(
    parameter logic [4:0] PAD_SYM = 5'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  sym_in,
    input  logic        sym_valid,
    output logic        sym_ready,
    input  logic [2:0]  take,
    input  logic        flush,
    input  logic        err_clr,
    output logic [49:0] win_data,
    output logic [3:0]  win_count,
    output logic        take_err,
    output logic [49:0] sh_in,
    output logic [2:0]  sh_shift,
    output logic [4:0]  sh_fill
);

    logic [49:0] win_q;
    logic [3:0]  cnt_q;
    logic        err_q;

    logic        take_ok;
    logic [2:0]  t;
    logic [3:0]  c1;
    logic        push;
    logic [49:0] shifted;
    logic [49:0] win_nxt;

    // Take legality, accept handshake and the effective shift amount.
    always_comb begin
        take_ok   = (take <= 3'd4) && ({1'b0, take} <= cnt_q);
        t         = take_ok ? take : 3'd0;
        c1        = cnt_q - {1'b0, t};
        sym_ready = ~flush & (cnt_q < 4'd10);
        push      = sym_valid & sym_ready;
    end

    // Shifter model: move lanes down by t, pad the vacated top lanes.
    always_comb begin
        shifted = {10{PAD_SYM}};
        for (int k = 0; k < 10; k++) begin
            if (k + int'(t) < 10)
                shifted[5*k +: 5] = win_q[5*(k + int'(t)) +: 5];
        end
    end

    // Refill: the pushed symbol lands in lane c1, right after the survivors.
    always_comb begin
        win_nxt = shifted;
        for (int k = 0; k < 10; k++) begin
            if (push && (c1 == 4'(k)))
                win_nxt[5*k +: 5] = sym_in;
        end
    end

    // Window and count registers; flush clears the window before any push/take.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_q <= {10{PAD_SYM}};
            cnt_q <= 4'd0;
        end else if (flush) begin
            win_q <= {10{PAD_SYM}};
            cnt_q <= 4'd0;
        end else begin
            win_q <= win_nxt;
            cnt_q <= push ? c1 + 4'd1 : c1;
        end
    end

    // Sticky illegal-take flag; a new error outranks a simultaneous clear.
    // A take presented during flush is ignored, so it cannot raise the flag.
    always_ff @(posedge clk) begin
        if (rst)
            err_q <= 1'b0;
        else if (!take_ok && !flush)
            err_q <= 1'b1;
        else if (err_clr)
            err_q <= 1'b0;
    end

    assign win_data  = win_q;
    assign win_count = cnt_q;
    assign take_err  = err_q;
    assign sh_in     = win_q;
    assign sh_shift  = t;
    assign sh_fill   = PAD_SYM;

endmodule

// File: tb/tb_symbol_window_loader.sv
// Directed bench for symbol_window_loader, built with a non-zero pad symbol
// so that empty lanes are distinguishable from symbol 0.
module tb_symbol_window_loader;

    localparam logic [4:0] PAD = 5'h15;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  sym_in;
    logic        sym_valid;
    logic        sym_ready;
    logic [2:0]  take;
    logic        flush;
    logic        err_clr;
    logic [49:0] win_data;
    logic [3:0]  win_count;
    logic        take_err;
    logic [49:0] sh_in;
    logic [2:0]  sh_shift;
    logic [4:0]  sh_fill;

    int n_vec = 0;
    int n_bad = 0;
    logic [49:0] exp_w;
    logic [49:0] pad_w;

    symbol_window_loader #(.PAD_SYM(PAD)) dut (
        .clk(clk), .rst(rst), .sym_in(sym_in), .sym_valid(sym_valid),
        .sym_ready(sym_ready), .take(take), .flush(flush), .err_clr(err_clr),
        .win_data(win_data), .win_count(win_count), .take_err(take_err),
        .sh_in(sh_in), .sh_shift(sh_shift), .sh_fill(sh_fill)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sym_valid = 1'b0; take = 3'd0; flush = 1'b0; err_clr = 1'b0;
    endtask

    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            sym_in = 5'(first + i); sym_valid = 1'b1;
            tick();
        end
        sym_valid = 1'b0;
        #1;
    endtask

    task automatic do_flush();
        flush = 1'b1; tick(); flush = 1'b0; #1;
    endtask

    initial begin
        pad_w = {10{PAD}};
        rst = 1'b1; sym_in = 5'd0; idle();
        tick(); tick();
        chk("rst_count", 64'(win_count), 64'd0);
        chk("rst_data", 64'(win_data), 64'(pad_w));
        chk("rst_err", 64'(take_err), 64'd0);
        chk("sh_fill", 64'(sh_fill), 64'(PAD));
        rst = 1'b0; tick();
        chk("ready_after_rst", 64'(sym_ready), 64'd1);

        // 1: fill the window with 1..10
        push_seq(1, 10);
        for (int k = 0; k < 10; k++) exp_w[5*k +: 5] = 5'(k + 1);
        chk("t1_count", 64'(win_count), 64'd10);
        chk("t1_data", 64'(win_data), 64'(exp_w));
        chk("t1_ready", 64'(sym_ready), 64'd0);
        chk("t1_sh_in", 64'(sh_in), 64'(exp_w));

        // 2: take 3 from a full window
        take = 3'd3; #1;
        chk("t2_sh_shift", 64'(sh_shift), 64'd3);
        tick(); take = 3'd0; #1;
        for (int k = 0; k < 10; k++) exp_w[5*k +: 5] = (k < 7) ? 5'(k + 4) : PAD;
        chk("t2_count", 64'(win_count), 64'd7);
        chk("t2_data", 64'(win_data), 64'(exp_w));
        chk("t2_ready", 64'(sym_ready), 64'd1);

        // 3: take 2 and push 1F in the same cycle
        do_flush();
        chk("t3_flush_count", 64'(win_count), 64'd0);
        push_seq(1, 5);
        take = 3'd2; sym_in = 5'h1F; sym_valid = 1'b1;
        tick(); idle(); #1;
        exp_w = pad_w;
        exp_w[4:0] = 5'd3; exp_w[9:5] = 5'd4; exp_w[14:10] = 5'd5; exp_w[19:15] = 5'h1F;
        chk("t3_count", 64'(win_count), 64'd4);
        chk("t3_data", 64'(win_data), 64'(exp_w));

        // 4: illegal takes leave the window alone and set the sticky error
        do_flush();
        push_seq(1, 2);
        exp_w = pad_w; exp_w[4:0] = 5'd1; exp_w[9:5] = 5'd2;
        take = 3'd3; #1;
        chk("t4_shift_gt_cnt", 64'(sh_shift), 64'd0);
        tick(); take = 3'd0; #1;
        chk("t4_err_a", 64'(take_err), 64'd1);
        chk("t4_data_a", 64'(win_data), 64'(exp_w));
        chk("t4_count_a", 64'(win_count), 64'd2);
        take = 3'd5; #1;
        chk("t4_shift_gt4", 64'(sh_shift), 64'd0);
        tick(); take = 3'd0; #1;
        chk("t4_count_b", 64'(win_count), 64'd2);
        tick();
        chk("t4_err_sticky", 64'(take_err), 64'd1);
        err_clr = 1'b1; tick(); err_clr = 1'b0; #1;
        chk("t4_err_clr", 64'(take_err), 64'd0);
        take = 3'd6; err_clr = 1'b1; tick(); idle(); #1;
        chk("t4_set_wins", 64'(take_err), 64'd1);
        chk("t4_data_c", 64'(win_data), 64'(exp_w));

        // 5: flush with push and take pending; error flag survives
        push_seq(3, 4);
        chk("t5_count_pre", 64'(win_count), 64'd6);
        flush = 1'b1; sym_valid = 1'b1; sym_in = 5'h07; take = 3'd1; #1;
        chk("t5_ready", 64'(sym_ready), 64'd0);
        tick(); idle(); #1;
        chk("t5_count", 64'(win_count), 64'd0);
        chk("t5_data", 64'(win_data), 64'(pad_w));
        chk("t5_err", 64'(take_err), 64'd1);

        // 6: reset in the middle of pushing
        push_seq(1, 8);
        chk("t6_count_pre", 64'(win_count), 64'd8);
        rst = 1'b1; sym_valid = 1'b1; sym_in = 5'h09;
        tick(); rst = 1'b0; idle(); #1;
        chk("t6_count", 64'(win_count), 64'd0);
        chk("t6_data", 64'(win_data), 64'(pad_w));
        chk("t6_err", 64'(take_err), 64'd0);
        chk("t6_ready", 64'(sym_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
